// File: rtl/rms_sched.sv
// Round-robin scheduler that shares one rms unit among NUM_REQ requesters.
// It grants one job at a time, adds the job's bank to the rms memory addresses, and flags jobs that time out.
package config_pkg;
  localparam int D = 8;
endpackage

module rms_sched
  import config_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int BANKS   = 4,
  parameter int TIMEOUT = 5 * D * D,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int ADDR_W = $clog2(D)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*BANK_W-1:0]   req_bank_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          done_o,
  output logic                        busy_o,
  output logic                        err_o,
  output logic                        rms_start_o,
  input  logic                        rms_ready_i,
  input  logic [ADDR_W-1:0]           rms_r_addr_i,
  input  logic [ADDR_W-1:0]           rms_w_addr_i,
  input  logic                        rms_w_en_i,
  output logic [BANK_W+ADDR_W-1:0]    mem_r_addr_o,
  output logic [BANK_W+ADDR_W-1:0]    mem_w_addr_o,
  output logic                        mem_w_en_o
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [BANK_W-1:0]  r_bank;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last;

  logic               w_found;
  logic               w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [BANK_W-1:0]  w_grant_bank;
  logic               w_in_wait;
  logic               w_timeout;

  // Two passes: requesters above the last winner first, then wrap to the rest.
  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    w_found      = 1'b0;
    w_grant_id   = '0;
    w_grant_bank = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid_i[i] && (ID_W'(i) > r_last)) begin
        w_found      = 1'b1;
        w_grant_id   = ID_W'(i);
        w_grant_bank = req_bank_i[i*BANK_W +: BANK_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid_i[i] && (ID_W'(i) <= r_last)) begin
        w_found      = 1'b1;
        w_grant_id   = ID_W'(i);
        w_grant_bank = req_bank_i[i*BANK_W +: BANK_W];
      end
    end
  end

  assign w_grant   = (r_state == IDLE) && rms_ready_i && w_found;
  assign w_in_wait = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
  assign w_timeout = w_in_wait && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_grant) w_next = START;
      START:     w_next = WAIT_BUSY;
      WAIT_BUSY: if (w_timeout) w_next = DONE;
                 else if (!rms_ready_i) w_next = WAIT_DONE;
      WAIT_DONE: if (w_timeout || rms_ready_i) w_next = DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_bank  <= '0;
      r_id    <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_bank <= w_grant_bank;
        r_id   <= w_grant_id;
        r_last <= w_grant_id;
      end
      if (r_state == START)
        r_cnt <= '0;
      else if (w_in_wait)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  // The grant pulse is combinational, so it is masked while reset is held.
  assign req_ready_o  = (w_grant && !rst_i) ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign done_o       = (r_state == DONE) ? (NUM_REQ'(1) << r_id) : '0;
  assign busy_o       = (r_state != IDLE);
  assign err_o        = r_err;
  assign rms_start_o  = (r_state == START);
  assign mem_r_addr_o = {r_bank, rms_r_addr_i};
  assign mem_w_addr_o = {r_bank, rms_w_addr_i};
  assign mem_w_en_o   = w_in_wait && rms_w_en_i;

endmodule
